pq_arbiter: RTL and testbench

//   Round-robin arbiter that shares one priority-queue instance between NREQ

---
 rtl/pq_arbiter_if.sv | 45 ++++
 rtl/pq_arbiter.sv | 154 +++++++++++++++
 tb/tb_pq_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pq_arbiter_if.sv
// Client and PQ-device signals of the round-robin PQ arbiter.
// master: arbiter side; slave: clients + PQ device side.
interface pq_arbiter_if #(
  parameter int NREQ = 4,
  parameter int KW   = 8,
  parameter int VW   = 8
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_op;
  logic [NREQ*KW-1:0] req_key;
  logic [NREQ*VW-1:0] req_val;
  logic [NREQ-1:0]    req_ack;
  logic [NREQ-1:0]    rsp_valid;
  logic [KW-1:0]      rsp_key;
  logic [VW-1:0]      rsp_val;
  logic               rsp_err;
  logic               arb_busy;
  logic               pq_enq;
  logic               pq_deq;
  logic [KW-1:0]      pq_kin;
  logic [VW-1:0]      pq_vin;
  logic [KW-1:0]      pq_kout;
  logic [VW-1:0]      pq_vout;
  logic               pq_full;
  logic               pq_empty;
  logic               pq_busy;

  modport master (
    input  req_valid, req_op, req_key, req_val,
    output req_ack, rsp_valid, rsp_key, rsp_val,
    output rsp_err, arb_busy,
    output pq_enq, pq_deq, pq_kin, pq_vin,
    input  pq_kout, pq_vout, pq_full, pq_empty,
    input  pq_busy
  );

  modport slave (
    output req_valid, req_op, req_key, req_val,
    input  req_ack, rsp_valid, rsp_key, rsp_val,
    input  rsp_err, arb_busy,
    input  pq_enq, pq_deq, pq_kin, pq_vin,
    output pq_kout, pq_vout, pq_full, pq_empty,
    output pq_busy
  );
endinterface

// File: rtl/pq_arbiter.sv
// Round-robin arbiter sharing one priority queue among NREQ clients.
// Ports: clk, rst_n (async low), bus (pq_arbiter_if.master).
module pq_arbiter #(
  parameter int NREQ    = 4,
  parameter int KW      = 8,
  parameter int VW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  pq_arbiter_if.master  bus
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [NREQ-1:0] ONE = 1;
  localparam logic [GW-1:0] LAST0 = GW'(NREQ - 1);
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  typedef struct packed {
    logic          op;
    logic [KW-1:0] key;
    logic [VW-1:0] val;
  } req_t;

  state_t        state;
  logic [GW-1:0] last;
  logic [GW-1:0] gnt;
  logic [CW-1:0] cnt;
  logic          rej_q;
  logic          op_q;

  logic          found;
  logic [GW-1:0] pick;
  req_t          sel;
  logic          rej;

  // Search upward from the client after the last one served.
  always_comb begin : pick_c
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  always_comb begin
    sel.op  = bus.req_op[pick];
    sel.key = bus.req_key[pick*KW +: KW];
    sel.val = bus.req_val[pick*VW +: VW];
    rej     = sel.op ? bus.pq_empty
                     : bus.pq_full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last          <= LAST0;
      gnt           <= '0;
      cnt           <= '0;
      rej_q         <= 1'b0;
      op_q          <= 1'b0;
      bus.req_ack   <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_key   <= '0;
      bus.rsp_val   <= '0;
      bus.rsp_err   <= 1'b0;
      bus.arb_busy  <= 1'b0;
      bus.pq_enq    <= 1'b0;
      bus.pq_deq    <= 1'b0;
      bus.pq_kin    <= '0;
      bus.pq_vin    <= '0;
    end else begin
      bus.req_ack <= '0;
      bus.pq_enq  <= 1'b0;
      bus.pq_deq  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            gnt          <= pick;
            op_q         <= sel.op;
            bus.req_ack  <= ONE << pick;
            bus.arb_busy <= 1'b1;
            if (rej) begin
              rej_q <= 1'b1;
              state <= RESP;
            end else begin
              state      <= ISSUE;
              bus.pq_enq <= !sel.op;
              bus.pq_deq <= sel.op;
              bus.pq_kin <= sel.op ? '0
                                   : sel.key;
              bus.pq_vin <= sel.op ? '0
                                   : sel.val;
            end
          end
        end
        ISSUE: begin
          bus.pq_kin <= '0;
          bus.pq_vin <= '0;
          cnt        <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          if (!bus.pq_busy) begin
            state         <= RESP;
            bus.rsp_valid <= ONE << gnt;
            bus.rsp_err   <= 1'b0;
            bus.rsp_key   <= op_q ? bus.pq_kout
                                  : '0;
            bus.rsp_val   <= op_q ? bus.pq_vout
                                  : '0;
          end else if (cnt == CMAX) begin
            state         <= RESP;
            bus.rsp_valid <= ONE << gnt;
            bus.rsp_err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          // A reject enters RESP one cycle early, so
          // its response pulse is raised here.
          if (rej_q) begin
            rej_q         <= 1'b0;
            bus.rsp_valid <= ONE << gnt;
            bus.rsp_err   <= 1'b1;
          end else begin
            bus.rsp_valid <= '0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_key   <= '0;
            bus.rsp_val   <= '0;
            bus.arb_busy  <= 1'b0;
            last          <= gnt;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pq_arbiter.sv
// Randomized self-checking bench for pq_arbiter.
// Behavioural PQ device plus transaction-level arbiter model.
module tb_pq_arbiter;

  localparam int N   = 4;
  localparam int T   = 16;
  localparam int CAP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pq_arbiter_if #(.NREQ(N), .KW(8), .VW(8)) bus ();

  pq_arbiter #(
    .NREQ(N), .KW(8), .VW(8), .TIMEOUT(T)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  typedef struct {
    logic [7:0] k;
    logic [7:0] v;
  } item_t;

  item_t      pq[$];
  logic [7:0] kout_m  = '0;
  logic [7:0] vout_m  = '0;
  logic       busy_m  = 1'b0;
  logic       full_m  = 1'b0;
  logic       empty_m = 1'b1;
  int         rem     = 0;
  int         lat_cfg = 0;

  assign bus.pq_kout  = kout_m;
  assign bus.pq_vout  = vout_m;
  assign bus.pq_busy  = busy_m;
  assign bus.pq_full  = full_m;
  assign bus.pq_empty = empty_m;

  // Sorted-list PQ; lat_cfg = busy cycles seen by the arbiter.
  always @(negedge clk) begin
    if (busy_m) begin
      rem = rem - 1;
      if (rem == 0) busy_m = 1'b0;
    end
    if (bus.pq_enq) begin
      int p;
      item_t it;
      p = pq.size();
      for (int i = pq.size() - 1; i >= 0; i--)
        if (pq[i].k > bus.pq_kin) p = i;
      it.k = bus.pq_kin;
      it.v = bus.pq_vin;
      pq.insert(p, it);
    end else if (bus.pq_deq && pq.size() > 0) begin
      kout_m = pq[0].k;
      vout_m = pq[0].v;
      void'(pq.pop_front());
    end
    if ((bus.pq_enq || bus.pq_deq) && lat_cfg > 0) begin
      busy_m = 1'b1;
      rem    = lat_cfg + 1;
    end
    full_m  = (pq.size() >= CAP);
    empty_m = (pq.size() == 0);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, act, exp);
    end
  endtask

  logic       cop  [N];
  logic [7:0] ckey [N];
  logic [7:0] cval [N];
  int         rr_last = N - 1;

  task automatic drive(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      bus.req_op[i]        = cop[i];
      bus.req_key[i*8 +: 8] = ckey[i];
      bus.req_val[i*8 +: 8] = cval[i];
    end
    bus.req_valid = mask;
  endtask

  task automatic outs_zero(input string tag);
    chk(tag, {bus.req_ack, bus.rsp_valid,
              bus.rsp_key, bus.rsp_val,
              bus.rsp_err, bus.arb_busy,
              bus.pq_enq, bus.pq_deq,
              bus.pq_kin, bus.pq_vin}, 64'd0);
  endtask

  // Called at a negedge while the arbiter is idle.
  task automatic txn(input logic [N-1:0] mask,
                     input bit hold,
                     input int lat);
    int g, n, ecyc;
    bit rej, err, isdeq;
    logic [7:0] hk, hv;
    g = -1;
    for (int k = 1; k <= N; k++)
      if (g < 0 && mask[(rr_last + k) % N])
        g = (rr_last + k) % N;
    isdeq = cop[g];
    rej = isdeq ? (pq.size() == 0)
                : (pq.size() >= CAP);
    hk = 8'h00;
    hv = 8'h00;
    if (isdeq && !rej) begin
      hk = pq[0].k;
      hv = pq[0].v;
    end
    err = rej || (lat >= T);
    ecyc = rej ? 2 : (lat >= T ? T + 2 : 3 + lat);
    lat_cfg = lat;
    drive(mask);
    @(negedge clk);
    chk("ack", bus.req_ack, 64'(1) << g);
    chk("pq_enq", bus.pq_enq, !rej && !isdeq);
    chk("pq_deq", bus.pq_deq, !rej && isdeq);
    chk("pq_kin", bus.pq_kin,
        (!rej && !isdeq) ? ckey[g] : 8'h00);
    chk("arb_busy", bus.arb_busy, 1);
    if (!hold) bus.req_valid = '0;
    n = 1;
    do begin
      @(negedge clk);
      n++;
    end while (bus.rsp_valid == '0 && n < T + 20);
    chk("rsp_cycle", n, ecyc);
    chk("rsp_valid", bus.rsp_valid, 64'(1) << g);
    chk("rsp_err", bus.rsp_err, err);
    chk("rsp_key", bus.rsp_key, err ? 8'h00 : hk);
    chk("rsp_val", bus.rsp_val, err ? 8'h00 : hv);
    @(negedge clk);
    chk("back_idle", {bus.arb_busy, bus.rsp_valid}, 0);
    rr_last = g;
    n = 0;
    while (busy_m && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic set_c(input int i, input logic op,
                       input logic [7:0] k,
                       input logic [7:0] v);
    cop[i]  = op;
    ckey[i] = k;
    cval[i] = v;
  endtask

  initial begin
    for (int i = 0; i < N; i++) set_c(i, 0, 0, 0);
    drive('0);
    repeat (3) @(negedge clk);
    outs_zero("reset_outs");
    rst_n = 1'b1;
    @(negedge clk);

    // single enqueue, then head 03/AA dequeued
    set_c(1, 0, 8'h05, 8'h11);
    txn(4'b0010, 0, 0);
    set_c(0, 0, 8'h03, 8'hAA);
    txn(4'b0001, 0, 0);
    set_c(2, 1, 8'h00, 8'h00);
    txn(4'b0100, 0, 4);

    // drain to empty then reject deq
    set_c(3, 1, 8'h00, 8'h00);
    txn(4'b1000, 0, 0);
    set_c(1, 1, 8'h00, 8'h00);
    txn(4'b0010, 0, 0);
    chk("no_deq_empty", pq.size(), 0);

    // fill to full then reject enq
    for (int i = 0; i < CAP + 1; i++) begin
      set_c(i % N, 0, 8'(8'h40 - i), 8'(i));
      txn(4'b0001 << (i % N), 0, 1);
    end
    chk("full_size", pq.size(), CAP);

    // stuck busy -> timeout
    set_c(2, 1, 8'h00, 8'h00);
    txn(4'b0100, 0, T + 2);

    // everyone holds requests continuously
    for (int i = 0; i < N; i++)
      set_c(i, i[0], 8'(8'h10 + i), 8'(i));
    for (int t = 0; t < 2 * N; t++)
      txn(4'b1111, 1, 0);
    bus.req_valid = '0;
    @(negedge clk);

    for (int t = 0; t < 150; t++) begin
      int r, lat;
      for (int i = 0; i < N; i++)
        set_c(i, 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)));
      r = $urandom_range(0, 9);
      lat = (r == 9) ? T + $urandom_range(0, 2)
                     : r % 4;
      txn(4'($urandom_range(1, 15)), 0, lat);
    end

    // async reset in the middle of WAIT
    set_c(1, 1, 8'h00, 8'h00);
    lat_cfg = 10;
    drive(4'b0010);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 outs_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    rr_last = N - 1;
    while (busy_m) @(negedge clk);
    set_c(0, 0, 8'h22, 8'h01);
    set_c(3, 0, 8'h33, 8'h02);
    txn(4'b1001, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
